data_memory_pipelined: RTL and testbench

Parametrised successor to the single-cycle data memory: word-addressed RAM with configurable data width, depth and read latency, byte-lane write masking, a read-valid strobe and out-of-range address detection. It sits between the CPU datapath's memory stage and the register-file write-back mux, and accepts one read, one write, or one read plus one write to the same address per clock.

---
 rtl/data_memory_pipelined_if.sv | 25 ++
 rtl/data_memory_pipelined.sv | 72 +++++++
 tb/tb_data_memory_pipelined.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pipelined_if.sv
// Memory-stage bus between the CPU datapath and the pipelined data memory.
// The datapath drives requests as master; the memory answers as slave.
interface data_memory_pipelined_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    memRead;
  logic                    memWrite;
  logic [DATA_WIDTH-1:0]   writeData;
  logic [DATA_WIDTH/8-1:0] writeMask;
  logic [DATA_WIDTH-1:0]   readData;
  logic                    readValid;
  logic                    addrError;

  modport master (
    output addr, memRead, memWrite, writeData, writeMask,
    input  readData, readValid, addrError
  );

  modport slave (
    input  addr, memRead, memWrite, writeData, writeMask,
    output readData, readValid, addrError
  );
endinterface

// File: rtl/data_memory_pipelined.sv
// Word-addressed data RAM with byte-lane write masking, write-first read
// capture and a READ_LATENCY-deep output pipeline carrying valid/error bits.
module data_memory_pipelined #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  data_memory_pipelined_if.slave bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

  // Power-up contents are zero; reset deliberately leaves the array alone.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] read_word;

  logic [READ_LATENCY-1:0] stage_valid;
  logic [READ_LATENCY-1:0] stage_err;
  logic [DATA_WIDTH-1:0]   stage_data [READ_LATENCY];

  // Full-width compare so an out-of-range address never aliases onto the array.
  assign in_range = {1'b0, bus.addr} < DEPTH_EXT;
  assign idx      = bus.addr[IDX_W-1:0];
  assign wr_en    = bus.memWrite && in_range && !reset;

  always_comb begin
    old_word    = mem[idx];
    merged_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (bus.writeMask[i]) merged_word[8*i +: 8] = bus.writeData[8*i +: 8];
    end
    read_word = '0;
    if (in_range) read_word = bus.memWrite ? merged_word : old_word;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[idx] <= merged_word;
  end

  // Each stage only reloads data when a read enters it, so the last stage
  // holds readData steady between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      stage_err   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) stage_data[i] <= '0;
    end else begin
      stage_valid[0] <= bus.memRead;
      stage_err[0]   <= (bus.memRead || bus.memWrite) && !in_range;
      if (bus.memRead) stage_data[0] <= read_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_err[i]   <= stage_err[i-1];
        if (stage_valid[i-1]) stage_data[i] <= stage_data[i-1];
      end
    end
  end

  assign bus.readData  = stage_data[READ_LATENCY-1];
  assign bus.readValid = stage_valid[READ_LATENCY-1];
  assign bus.addrError = stage_err[READ_LATENCY-1];
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Drives identical traffic into a latency-1 and a latency-3 memory and checks
// both against a per-edge reference model of array contents and result timing.
module tb_data_memory_pipelined;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int MW    = DW / 8;
  localparam int DEPTH = 1024;

  typedef struct packed { logic v; logic e; logic [DW-1:0] d; } obs_t;
  typedef struct { int due; logic v; logic e; logic [DW-1:0] d; } exp_t;
  typedef struct { logic rd; logic wr; logic [AW-1:0] a; logic [DW-1:0] wd; logic [MW-1:0] m; } stim_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_memory_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  data_memory_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

  data_memory_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave));
  data_memory_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3.slave));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] mem_m [DEPTH] = '{default: '0};
  exp_t q1 [$];
  exp_t q3 [$];
  logic [DW-1:0] held1 = '0;
  logic [DW-1:0] held3 = '0;

  task automatic drive(input stim_t s);
    bus1.memRead = s.rd; bus1.memWrite = s.wr; bus1.addr = s.a; bus1.writeData = s.wd; bus1.writeMask = s.m;
    bus3.memRead = s.rd; bus3.memWrite = s.wr; bus3.addr = s.a; bus3.writeData = s.wd; bus3.writeMask = s.m;
  endtask

  // Reference: apply the access to the model array, then schedule the result
  // for the edge where each latency variant must present it.
  task automatic model_edge(input stim_t s);
    bit oor;
    exp_t ent;
    logic [DW-1:0] word;
    oor  = (s.a >= AW'(DEPTH)) || (DEPTH == (1 << AW) ? 1'b0 : 1'b0);
    word = '0;
    if (s.wr && !oor)
      for (int i = 0; i < MW; i++) if (s.m[i]) mem_m[s.a][8*i +: 8] = s.wd[8*i +: 8];
    if (s.rd && !oor) word = mem_m[s.a];
    if (s.rd || s.wr) begin
      ent.v = s.rd; ent.e = oor; ent.d = word;
      ent.due = cyc;     q1.push_back(ent);
      ent.due = cyc + 2; q3.push_back(ent);
    end
  endtask

  function automatic obs_t take(input int which);
    obs_t r;
    exp_t ent;
    r = '0;
    if (which == 1) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        ent = q1.pop_front();
        if (ent.v) held1 = ent.d;
        r.v = ent.v; r.e = ent.e;
      end
      r.d = held1;
    end else begin
      if (q3.size() > 0 && q3[0].due == cyc) begin
        ent = q3.pop_front();
        if (ent.v) held3 = ent.d;
        r.v = ent.v; r.e = ent.e;
      end
      r.d = held3;
    end
    return r;
  endfunction

  task automatic step(input stim_t s, output obs_t o1, output obs_t e1, output obs_t o3, output obs_t e3);
    drive(s);
    @(posedge clock);
    cyc++;
    if (!reset) model_edge(s);
    #1;
    o1 = {bus1.readValid, bus1.addrError, bus1.readData};
    o3 = {bus3.readValid, bus3.addrError, bus3.readData};
    e1 = take(1);
    e3 = take(3);
  endtask

  function automatic void model_reset();
    q1.delete(); q3.delete();
    held1 = '0; held3 = '0;
  endfunction

  task automatic test_reset();
    stim_t s [3] = '{'{1'b1, 1'b0, 16'd0, 16'd0, 2'b00}, '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00},
                     '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00}};
    obs_t o1, e1, o3, e3;
    drive(s[1]);
    #12;
    n_cmp++;
    if ({bus1.readValid, bus1.addrError, bus1.readData, bus3.readValid, bus3.addrError, bus3.readData} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got lat1=%h lat3=%h want 0", {bus1.readValid, bus1.addrError, bus1.readData},
               {bus3.readValid, bus3.addrError, bus3.readData});
    end
    #8 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(s[i], o1, e1, o3, e3);
      n_cmp++;
      if ({o1, o3} !== {e1, e3}) begin
        n_fail++; $display("FAIL reset_first_read step %0d: got %h/%h want %h/%h", i, o1, o3, e1, e3);
      end
      if (i == 0) begin
        n_cmp++;
        if (o1 !== {1'b1, 1'b0, 16'd0}) begin n_fail++; $display("FAIL reset_read0_lat1: got %h want 20000", o1); end
      end
      if (i == 2) begin
        n_cmp++;
        if (o3 !== {1'b1, 1'b0, 16'd0}) begin n_fail++; $display("FAIL reset_read0_lat3: got %h want 20000", o3); end
      end
    end
  endtask

  task automatic test_write_mask();
    stim_t s [7] = '{'{1'b0, 1'b1, 16'd0, 16'd15, 2'b11}, '{1'b1, 1'b0, 16'd0, 16'd0, 2'b00},
                     '{1'b0, 1'b1, 16'd3, 16'h1234, 2'b11}, '{1'b0, 1'b1, 16'd3, 16'hFF00, 2'b10},
                     '{1'b1, 1'b0, 16'd3, 16'd0, 2'b00}, '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00},
                     '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00}};
    obs_t o1, e1, o3, e3;
    for (int i = 0; i < 7; i++) begin
      step(s[i], o1, e1, o3, e3);
      n_cmp++;
      if ({o1, o3} !== {e1, e3}) begin
        n_fail++; $display("FAIL write_mask step %0d: got %h/%h want %h/%h", i, o1, o3, e1, e3);
      end
      if (i == 1) begin
        n_cmp++;
        if (o1 !== {1'b1, 1'b0, 16'd15}) begin n_fail++; $display("FAIL write_full_word: got %h want 2000f", o1); end
      end
      if (i == 4) begin
        n_cmp++;
        if (o1.d !== 16'hFF34) begin n_fail++; $display("FAIL lane_merge_lat1: got %h want ff34", o1.d); end
      end
      if (i == 6) begin
        n_cmp++;
        if (o3 !== {1'b1, 1'b0, 16'hFF34}) begin n_fail++; $display("FAIL lane_merge_lat3: got %h want 2ff34", o3); end
      end
    end
  endtask

  task automatic test_rw_same();
    stim_t s [3] = '{'{1'b1, 1'b1, 16'd5, 16'hABCD, 2'b11}, '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00},
                     '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00}};
    obs_t o1, e1, o3, e3;
    for (int i = 0; i < 3; i++) begin
      step(s[i], o1, e1, o3, e3);
      n_cmp++;
      if ({o1, o3} !== {e1, e3}) begin
        n_fail++; $display("FAIL rw_same step %0d: got %h/%h want %h/%h", i, o1, o3, e1, e3);
      end
      if (i == 0) begin
        n_cmp++;
        if (o1 !== {1'b1, 1'b0, 16'hABCD}) begin n_fail++; $display("FAIL write_first_lat1: got %h want 2abcd", o1); end
      end
      if (i == 2) begin
        n_cmp++;
        if (o3 !== {1'b1, 1'b0, 16'hABCD}) begin n_fail++; $display("FAIL write_first_lat3: got %h want 2abcd", o3); end
      end
    end
  endtask

  task automatic test_out_of_range();
    stim_t s [6] = '{'{1'b0, 1'b1, 16'd1024, 16'd7, 2'b11}, '{1'b1, 1'b0, 16'd1024, 16'd0, 2'b00},
                     '{1'b1, 1'b0, 16'd0, 16'd0, 2'b00}, '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00},
                     '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00}, '{1'b1, 1'b1, 16'hFFFF, 16'h1111, 2'b11}};
    obs_t o1, e1, o3, e3;
    for (int i = 0; i < 6; i++) begin
      step(s[i], o1, e1, o3, e3);
      n_cmp++;
      if ({o1, o3} !== {e1, e3}) begin
        n_fail++; $display("FAIL out_of_range step %0d: got %h/%h want %h/%h", i, o1, o3, e1, e3);
      end
      if (i == 0) begin
        n_cmp++;
        if ({o1.v, o1.e} !== 2'b01) begin n_fail++; $display("FAIL oor_write_strobe: got v=%b e=%b want v=0 e=1", o1.v, o1.e); end
      end
      if (i == 1) begin
        n_cmp++;
        if (o1 !== {1'b1, 1'b1, 16'd0}) begin n_fail++; $display("FAIL oor_read_zero: got %h want 30000", o1); end
      end
      if (i == 2) begin
        n_cmp++;
        if (o1 !== {1'b1, 1'b0, 16'd15}) begin n_fail++; $display("FAIL no_alias_addr0: got %h want 2000f", o1); end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s [15] = '{'{1'b0, 1'b1, 16'd0, 16'd10, 2'b11}, '{1'b0, 1'b1, 16'd1, 16'd11, 2'b11},
                      '{1'b0, 1'b1, 16'd2, 16'd12, 2'b11}, '{1'b1, 1'b0, 16'd0, 16'd0, 2'b00},
                      '{1'b1, 1'b0, 16'd1, 16'd0, 2'b00}, '{1'b1, 1'b0, 16'd2, 16'd0, 2'b00},
                      '{1'b0, 1'b1, 16'd1, 16'd99, 2'b11}, '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00},
                      '{1'b0, 1'b1, 16'd4, 16'h0044, 2'b11}, '{1'b1, 1'b0, 16'd4, 16'd0, 2'b00},
                      '{1'b0, 1'b1, 16'd4, 16'h5555, 2'b11}, '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00},
                      '{1'b1, 1'b0, 16'd1, 16'd0, 2'b00}, '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00},
                      '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00}};
    obs_t o1, e1, o3, e3;
    for (int i = 0; i < 15; i++) begin
      step(s[i], o1, e1, o3, e3);
      n_cmp++;
      if ({o1, o3} !== {e1, e3}) begin
        n_fail++; $display("FAIL back_to_back step %0d: got %h/%h want %h/%h", i, o1, o3, e1, e3);
      end
      if (i >= 5 && i <= 7) begin
        n_cmp++;
        if (o3 !== {1'b1, 1'b0, 16'(i + 5)}) begin
          n_fail++; $display("FAIL in_order_lat3 step %0d: got %h want data %0d valid", i, o3, i + 5);
        end
      end
      if (i == 11) begin
        n_cmp++;
        if (o3 !== {1'b1, 1'b0, 16'h0044}) begin n_fail++; $display("FAIL capture_immune: got %h want 20044", o3); end
      end
      if (i == 14) begin
        n_cmp++;
        if (o3 !== {1'b1, 1'b0, 16'd99}) begin n_fail++; $display("FAIL later_write_seen: got %h want 20063", o3); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    stim_t idle = '{1'b0, 1'b0, 16'd0, 16'd0, 2'b00};
    stim_t rd0  = '{1'b1, 1'b0, 16'd0, 16'd0, 2'b00};
    stim_t wr0  = '{1'b0, 1'b1, 16'd0, 16'hDEAD, 2'b11};
    obs_t o1, e1, o3, e3;
    step(rd0, o1, e1, o3, e3);
    n_cmp++;
    if ({o1, o3} !== {e1, e3}) begin n_fail++; $display("FAIL midflight_issue: got %h/%h want %h/%h", o1, o3, e1, e3); end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus1.readValid, bus1.readData, bus3.readValid, bus3.addrError, bus3.readData} !== '0) begin
      n_fail++; $display("FAIL async_reset_clear: got lat1 v=%b d=%h lat3 v=%b e=%b d=%h want all 0",
                         bus1.readValid, bus1.readData, bus3.readValid, bus3.addrError, bus3.readData);
    end
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(idle, o1, e1, o3, e3);
      n_cmp++;
      if ({o1, o3} !== {e1, e3}) begin
        n_fail++; $display("FAIL midflight_discard step %0d: got %h/%h want %h/%h", i, o1, o3, e1, e3);
      end
    end
    reset = 1'b1;
    drive(wr0);
    @(posedge clock);
    cyc++;
    #1 drive(idle);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(i == 0 ? rd0 : idle, o1, e1, o3, e3);
      n_cmp++;
      if ({o1, o3} !== {e1, e3}) begin
        n_fail++; $display("FAIL post_reset step %0d: got %h/%h want %h/%h", i, o1, o3, e1, e3);
      end
      if (i == 2) begin
        n_cmp++;
        if (o3 !== {1'b1, 1'b0, 16'd10}) begin n_fail++; $display("FAIL array_kept: got %h want 2000a", o3); end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    obs_t o1, e1, o3, e3;
    for (int i = 0; i < 400; i++) begin
      s.rd = 1'($urandom);
      s.wr = 1'($urandom);
      case ($urandom_range(0, 3))
        0: s.a = 16'($urandom_range(0, 7));
        1: s.a = 16'($urandom_range(1016, 1023));
        2: s.a = 16'($urandom_range(1024, 1027));
        default: s.a = 16'($urandom);
      endcase
      s.wd = 16'($urandom);
      s.m  = 2'($urandom);
      if (i >= 398) begin s.rd = 1'b0; s.wr = 1'b0; end
      step(s, o1, e1, o3, e3);
      n_cmp++;
      if ({o1, o3} !== {e1, e3}) begin
        n_fail++; $display("FAIL random step %0d: got %h/%h want %h/%h", i, o1, o3, e1, e3);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_mask();
    test_rw_same();
    test_out_of_range();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
